// File: rtl/jt03_slot_seq.sv
// +----------------------------------------------------------------------------+
// | jt03_slot_seq: double-buffered 12-slot operator result replay sequencer    |
// | for the YM2203 mono accumulator (3 channels x 4 operators, 14-bit data).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jt03_slot_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        wr,
  input  logic [3:0]  wr_addr,
  input  logic [13:0] wr_data,
  input  logic        alg_wr,
  input  logic [1:0]  alg_ch,
  input  logic [2:0]  alg_data,
  output logic [13:0] op_result,
  output logic        s1_enters,
  output logic        s2_enters,
  output logic        s3_enters,
  output logic        s4_enters,
  output logic        zero,
  output logic [2:0]  alg,
  output logic        snap
);

  localparam logic [3:0] C_LAST_SLOT = 4'd11;

  logic [13:0] shadow_q     [0:11];
  logic [13:0] active_q     [0:11];
  logic [2:0]  shadow_alg_q [0:2];
  logic [2:0]  active_alg_q [0:2];

  logic [3:0]  slot_q, slot_d;
  logic [13:0] op_result_q, op_result_d;
  logic [2:0]  alg_q, alg_d;
  logic [3:0]  markers_q, markers_d;
  logic        zero_q, zero_d;
  logic        snap_q;

  logic        wrap;
  logic [3:0]  idx_d;

  // Slot order is channel-fastest; operator groups follow the YM order S1,S3,S2,S4.
  always_comb begin
    wrap   = (slot_q == C_LAST_SLOT);
    slot_d = wrap ? 4'd0 : slot_q + 4'd1;
    idx_d  = 4'b0000;
    case (slot_d)
      4'd0:    idx_d = 4'b0000;
      4'd1:    idx_d = 4'b0100;
      4'd2:    idx_d = 4'b1000;
      4'd3:    idx_d = 4'b0010;
      4'd4:    idx_d = 4'b0110;
      4'd5:    idx_d = 4'b1010;
      4'd6:    idx_d = 4'b0001;
      4'd7:    idx_d = 4'b0101;
      4'd8:    idx_d = 4'b1001;
      4'd9:    idx_d = 4'b0011;
      4'd10:   idx_d = 4'b0111;
      4'd11:   idx_d = 4'b1011;
      default: idx_d = 4'b0000;
    endcase
    // Slot 0 reads straight from shadow so it sees the snapshot taken on this edge.
    op_result_d = wrap ? shadow_q[idx_d] : active_q[idx_d];
    alg_d       = wrap ? shadow_alg_q[idx_d[3:2]] : active_alg_q[idx_d[3:2]];
    markers_d   = 4'b0001 << idx_d[1:0];
    zero_d      = (slot_d == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 12; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int c = 0; c < 3; c++) begin
        shadow_alg_q[c] <= '0;
        active_alg_q[c] <= '0;
      end
      slot_q      <= C_LAST_SLOT;
      op_result_q <= '0;
      alg_q       <= '0;
      markers_q   <= '0;
      zero_q      <= 1'b0;
      snap_q      <= 1'b0;
    end else begin
      snap_q <= clk_en && wrap;
      if (clk_en) begin
        slot_q      <= slot_d;
        op_result_q <= op_result_d;
        alg_q       <= alg_d;
        markers_q   <= markers_d;
        zero_q      <= zero_d;
        if (wrap) begin
          for (int i = 0; i < 12; i++) active_q[i] <= shadow_q[i];
          for (int c = 0; c < 3; c++) active_alg_q[c] <= shadow_alg_q[c];
        end
      end
      // A write on the snapshot edge lands in shadow only, after the copy samples it.
      if (wr && (wr_addr[3:2] != 2'b11)) shadow_q[wr_addr] <= wr_data;
      if (alg_wr && (alg_ch != 2'b11)) shadow_alg_q[alg_ch] <= alg_data;
    end
  end

  assign op_result = op_result_q;
  assign alg       = alg_q;
  assign s1_enters = markers_q[0];
  assign s2_enters = markers_q[1];
  assign s3_enters = markers_q[2];
  assign s4_enters = markers_q[3];
  assign zero      = zero_q;
  assign snap      = snap_q;

endmodule

`default_nettype wire
